pipeline_fetch: RTL

PIPELINE_FETCH -- requirements
Module: pipeline_fetch

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/pipeline_fetch_if.sv | 28 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/pipeline_fetch.sv | 99 +++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the instruction fetch stage.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/pipeline_fetch_if.sv
// Instruction-memory, redirect and decode-side signals of the fetch stage.
interface pipeline_fetch_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;

  // Fetch stage side
  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instruction_o, pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );

  // Memory / pipeline environment side
  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instruction_o, pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO of {pc, instr} entries with synchronous flush.
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_entry_t    store_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = store_q[rptr_q];

  // Pointer and occupancy update; flush overrides push and pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) store_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// buffering and redirect handling with stale-response discard.
module pipeline_fetch
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  pipeline_fetch_if.master        bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = CntW + 2;

  fetch_state_t    state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] fifo_count;
  logic [SumW-1:0] inflight;
  logic            req, grant, rsp_keep, rsp_drop, push, pop, fifo_full, fifo_empty;
  logic [31:0]     redirect_target;
  fetch_entry_t    fifo_wdata, fifo_rdata;

  // Old responses still owed (discard) occupy credit until they drain.
  assign inflight = SumW'(outstanding_q) + SumW'(discard_q) + SumW'(fifo_count);
  assign req      = (state_q == RUN) && !bus.redirect_i && (inflight < SumW'(FIFO_DEPTH));
  assign grant    = req && bus.imem_gnt_i;
  assign rsp_keep = bus.imem_rvalid_i && (discard_q == '0);
  assign rsp_drop = bus.imem_rvalid_i && (discard_q != '0);
  assign push     = rsp_keep && !bus.redirect_i;
  assign pop      = !fifo_empty && bus.instr_ready_i;

  assign redirect_target = {bus.redirect_pc_i[31:2], 2'b00};
  assign fifo_wdata      = '{pc: rsp_pc_q, instr: bus.imem_rdata_i};

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = !fifo_empty;
  assign bus.instruction_o = fifo_empty ? NOP_INSTR : fifo_rdata.instr;
  assign bus.pc_o          = fifo_empty ? 32'h0 : fifo_rdata.pc;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .flush  (bus.redirect_i),
    .wdata  (fifo_wdata),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Next fetch address, response tag and credit bookkeeping; redirect wins.
  always_comb begin
    state_d       = RUN;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (bus.redirect_i) begin
      fetch_pc_d    = redirect_target;
      rsp_pc_d      = redirect_target;
      outstanding_d = '0;
      // Everything still owed by memory, less any response landing now, is stale.
      discard_d     = outstanding_q + discard_q - CntW'(bus.imem_rvalid_i);
    end else begin
      if (grant)    fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_keep) rsp_pc_d   = rsp_pc_q + 32'd4;
      if (rsp_drop) discard_d  = discard_q - CntW'(1);
      outstanding_d = outstanding_q + CntW'(grant) - CntW'(rsp_keep);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule
